valve_pulse_driver: RTL
=======================

# valve_pulse_driver

Actuator-side counterpart of the button debouncer in the irrigation controller. It consumes the clean single-cycle command pulses the controller derives from debounced buttons and turns them into a held valve-drive level of programmed length. A mandatory off-time guard after every closing keeps the solenoid from chattering. It sits between the controller FSM and the valve/pump output pin.

## Interface
- CNT_W, 16, width of duration/remaining counters
- MIN_OFF, 1000, guard cycles after the valve closes; 0 disables the guard; must fit in CNT_W

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (clears everything while 0)
- start  in  1  single-cycle request to open the valve
- stop  in  1  single-cycle request to close the valve early
- duration  in  CNT_W  requested open time in clock cycles, sampled only on an accepted start
- valve  out  1  valve drive level, 1 = open
- busy  out  1  1 while OPEN or GUARD
- done  out  1  one-cycle pulse, natural end of a timed run
- aborted  out  1  one-cycle pulse, run ended by stop
- remaining  out  CNT_W  cycles of open time left; 0 outside OPEN

## Operation
- States: IDLE, OPEN, GUARD. All outputs are registered.
- Reset (reset=0): state IDLE, counter 0, valve=0, busy=0, done=0, aborted=0, remaining=0. Applies immediately, mid-run included; the valve closes asynchronously.
- IDLE:
  - start=1 with duration≠0 → OPEN, counter←duration.
  - start with duration=0 is ignored: no state change, no pulse.
  - stop is ignored.
- OPEN:
  - valve=1; remaining=counter.
  - Each edge: if stop=1 → GUARD with aborted pulse.
  - Else if counter=1 → GUARD with done pulse.
  - Else counter←counter−1.
  - stop wins over natural completion in the same cycle, giving aborted=1 and done=0.
  - start is ignored. There is no retrigger or extension.
- GUARD:
  - valve=0, busy=1, counter←MIN_OFF on entry.
  - Each edge: if counter≤1 → IDLE, else decrement.
  - start and stop are ignored.
  - With MIN_OFF=0, OPEN exits directly to IDLE and busy drops together with valve.
- done and aborted are never high together and never high for more than one cycle.
- start and stop high in the same IDLE cycle: start is accepted and stop is ignored.

## Timing
- start sampled at edge k (IDLE, duration=D):
  - valve=1 and busy=1 after edge k.
  - remaining=D after edge k, then D−1, …, 1.
  - valve=0 after edge k+D, exactly D cycles high.
  - done=1 during the cycle after edge k+D.
- stop sampled at edge m in OPEN: valve=0 and aborted=1 after edge m; latency 1 cycle.
- Guard: busy stays 1 until edge k+D+MIN_OFF, then 0. The earliest start accepted is the one sampled at edge k+D+MIN_OFF+1; a start at edge k+D+MIN_OFF is dropped.
- duration=1 gives exactly one cycle of valve=1.
- duration=2^CNT_W−1 must run the full count with no wrap.

## Structure
- Package valve_pkg holds:
  - state enum (IDLE, OPEN, GUARD)
  - default CNT_W and MIN_OFF constants
- One sub-module, down_counter (load, decrement, value, is_one flag), shared by the OPEN and GUARD phases.
- The FSM lives in valve_pulse_driver.

## Test plan
- Reset then start with duration=5 → valve high exactly 5 cycles, remaining 5,4,3,2,1, done one cycle as valve falls, busy low MIN_OFF cycles later.
- start with duration=100, stop at cycle 40 → valve falls 1 cycle after stop, aborted=1 once, done never asserts, guard still enforced.
- Run duration=3; start pulses during OPEN and at every GUARD cycle including the last → all ignored; a start one cycle later is accepted.
- stop coincident with the counter=1 cycle → aborted=1, done=0, valve closes at the same edge as a natural finish.
- start with duration=0, and stop in IDLE → no output change at all.
- reset pulled low mid-OPEN (remaining=50) → valve/busy/remaining 0 immediately. After release, a start with duration=2 behaves as a fresh run with no guard carried over.
- MIN_OFF=0 build: back-to-back runs; a start the cycle after done is accepted.

Source files
------------

// File: rtl/valve_pkg.sv
// Shared types and default build constants for the valve pulse driver.
package valve_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned MIN_OFF_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        GUARD = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter shared by the open-time and guard-time phases.
module down_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         is_one
);

    // is_one is tracked alongside value so the FSM sees a registered flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value  <= '0;
            is_one <= 1'b0;
        end else if (load) begin
            value  <= load_val;
            is_one <= (load_val == W'(1));
        end else if (dec) begin
            value  <= value - W'(1);
            is_one <= (value == W'(2));
        end
    end

endmodule

// File: rtl/valve_pulse_driver.sv
// Turns single-cycle start/stop commands into a timed valve-open level
// followed by a mandatory off-time guard.
module valve_pulse_driver
    import valve_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned MIN_OFF = MIN_OFF_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] duration,
    output logic             valve,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [CNT_W-1:0] GUARD_LEN = CNT_W'(MIN_OFF);
    localparam bit               HAS_GUARD = (MIN_OFF != 0);

    state_t           state_q;
    state_t           state_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_is_one;
    logic             valve_d;
    logic             busy_d;
    logic             done_d;
    logic             aborted_d;
    logic [CNT_W-1:0] remaining_d;

    down_counter #(.W(CNT_W)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .is_one   (cnt_is_one)
    );

    // Next state, counter control and next output values
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        valve_d      = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        remaining_d  = '0;
        case (state_q)
            IDLE: begin
                if (start && (duration != '0)) begin
                    state_d      = OPEN;
                    cnt_load     = 1'b1;
                    cnt_load_val = duration;
                    valve_d      = 1'b1;
                    busy_d       = 1'b1;
                    remaining_d  = duration;
                end
            end
            OPEN: begin
                if (stop || cnt_is_one) begin
                    // stop takes priority over a natural finish in the same cycle
                    aborted_d = stop;
                    done_d    = !stop;
                    if (HAS_GUARD) begin
                        state_d      = GUARD;
                        cnt_load     = 1'b1;
                        cnt_load_val = GUARD_LEN;
                        busy_d       = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec     = 1'b1;
                    valve_d     = 1'b1;
                    busy_d      = 1'b1;
                    remaining_d = cnt_value - CNT_W'(1);
                end
            end
            GUARD: begin
                if (cnt_is_one || (cnt_value == '0)) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            valve     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            remaining <= '0;
        end else begin
            state_q   <= state_d;
            valve     <= valve_d;
            busy      <= busy_d;
            done      <= done_d;
            aborted   <= aborted_d;
            remaining <= remaining_d;
        end
    end

endmodule
